// File: rtl/bcd_scan_7seg.sv
// bcd_scan_7seg: five-digit multiplexed 7-segment scanner with double-buffered BCD load and leading-zero blanking
module bcd_scan_7seg #(
    parameter int PRESCALE = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] BCD_0,
    input  logic [3:0] BCD_1,
    input  logic [3:0] BCD_2,
    input  logic [3:0] BCD_3,
    input  logic [3:0] BCD_4,
    input  logic       blank_en,
    output logic [6:0] SEG,
    output logic [4:0] DIG_EN,
    output logic       frame_done
);
    localparam int CW = $clog2(PRESCALE);
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [19:0]   pend_q, disp_q;
    logic          pend_v_q;
    logic          tick, wrap, blank;
    logic [3:0]    digit;
    logic [6:0]    seg_d;
    assign tick       = cnt_q == CW'(PRESCALE - 1);
    assign wrap       = tick && idx_q == 3'd4;
    assign frame_done = wrap;
    assign digit      = disp_q[{idx_q, 2'b00} +: 4];
    // digits idx..4 are all zero exactly when the display shifted down to idx is zero
    assign blank      = blank_en && idx_q != 3'd0 && (disp_q >> {idx_q, 2'b00}) == 20'd0;
    always_comb begin
        case (digit)
            4'd0:    seg_d = 7'b1000000;
            4'd1:    seg_d = 7'b1111001;
            4'd2:    seg_d = 7'b0100100;
            4'd3:    seg_d = 7'b0110000;
            4'd4:    seg_d = 7'b0011001;
            4'd5:    seg_d = 7'b0010010;
            4'd6:    seg_d = 7'b0000010;
            4'd7:    seg_d = 7'b1111000;
            4'd8:    seg_d = 7'b0000000;
            4'd9:    seg_d = 7'b0010000;
            default: seg_d = 7'b0000110;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            disp_q   <= '0;
            SEG      <= 7'h7f;
            DIG_EN   <= 5'h1f;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick) idx_q <= wrap ? 3'd0 : idx_q + 3'd1;
            if (wrap && pend_v_q) disp_q <= pend_q;
            if (load) pend_q <= {BCD_4, BCD_3, BCD_2, BCD_1, BCD_0};
            // a load landing on the wrap survives as the next frame's pending data
            pend_v_q <= load || (pend_v_q && !wrap);
            SEG      <= blank ? 7'h7f : seg_d;
            DIG_EN   <= ~(5'd1 << idx_q);
        end
    end
endmodule

// File: tb/tb_bcd_scan_7seg.sv
// tb_bcd_scan_7seg: scoreboard bench driving directed and random loads against a frame-level reference model
module tb_bcd_scan_7seg;
    localparam int P = 4;
    localparam int F = 5 * P;
    typedef struct packed {
        logic [6:0] seg;
        logic [4:0] dig;
        logic       fd;
    } exp_t;
    logic        clk = 1'b0, rst = 1'b1, load = 1'b0, blank_en = 1'b0;
    logic [19:0] bcd = '0;
    logic [6:0]  SEG;
    logic [4:0]  DIG_EN;
    logic        frame_done;
    exp_t        q[$];
    int          checks = 0, failures = 0, pushes = 0, pops = 0;
    int          k = 0;
    logic        pv = 1'b0;
    logic [19:0] pend = '0, disp = '0;
    logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    bcd_scan_7seg #(.PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .load(load),
        .BCD_0(bcd[3:0]), .BCD_1(bcd[7:4]), .BCD_2(bcd[11:8]), .BCD_3(bcd[15:12]), .BCD_4(bcd[19:16]),
        .blank_en(blank_en), .SEG(SEG), .DIG_EN(DIG_EN), .frame_done(frame_done)
    );
    always #5 clk = ~clk;
    function automatic logic [6:0] expect_seg(input int slot);
        logic [3:0] d;
        logic       zeros;
        d = disp[4*slot +: 4];
        zeros = 1'b1;
        for (int j = slot; j < 5; j++) if (disp[4*j +: 4] != 4'd0) zeros = 1'b0;
        if (blank_en && slot >= 1 && zeros) return 7'h7f;
        return d > 4'd9 ? 7'b0000110 : seg_tab[d];
    endfunction
    task automatic chk(input string n, input logic [6:0] a, input logic [6:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s t=%0t got=%b exp=%b", n, $time, a, x);
        end
    endtask
    task automatic step(input logic r, input logic ld, input logic [19:0] b, input logic be);
        exp_t e;
        @(negedge clk);
        rst = r;
        load = ld;
        bcd = b;
        blank_en = be;
        if (r) begin
            e.seg = 7'h7f;
            e.dig = 5'h1f;
            k = 0;
            pend = '0;
            pv = 1'b0;
            disp = '0;
        end else begin
            e.dig = ~(5'd1 << ((k / P) % 5));
            e.seg = expect_seg((k / P) % 5);
            if (k % F == F - 1) begin
                if (pv) disp = pend;
                pv = 1'b0;
            end
            if (ld) begin
                pend = b;
                pv = 1'b1;
            end
            k++;
        end
        e.fd = (k % F == F - 1);
        q.push_back(e);
        pushes++;
    endtask
    task automatic idle_to(input int phase, input logic be);
        for (int n = 0; n < F && k % F != phase; n++) step(1'b0, 1'b0, 20'h0, be);
    endtask
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            pops++;
            chk("SEG", SEG, e.seg);
            chk("DIG_EN", {2'b00, DIG_EN}, {2'b00, e.dig});
            chk("frame_done", {6'd0, frame_done}, {6'd0, e.fd});
        end
    end
    initial begin
        step(1'b1, 1'b0, 20'h0, 1'b0);
        step(1'b1, 1'b1, 20'h12345, 1'b0);
        repeat (40) step(1'b0, 1'b0, 20'h0, 1'b0);
        idle_to(7, 1'b0);
        step(1'b0, 1'b1, 20'h43210, 1'b0);
        repeat (2 * F) step(1'b0, 1'b0, 20'h0, 1'b0);
        step(1'b0, 1'b1, 20'h00070, 1'b1);
        repeat (2 * F) step(1'b0, 1'b0, 20'h0, 1'b1);
        repeat (F) step(1'b0, 1'b0, 20'h0, 1'b0);
        step(1'b0, 1'b1, 20'h11111, 1'b0);
        idle_to(F - 1, 1'b0);
        step(1'b0, 1'b1, 20'h99999, 1'b0);
        repeat (2 * F) step(1'b0, 1'b0, 20'h0, 1'b0);
        step(1'b0, 1'b1, 20'h00C00, 1'b1);
        repeat (2 * F) step(1'b0, 1'b0, 20'h0, 1'b1);
        repeat (400) step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 7) == 0),
                          20'($urandom), 1'($urandom_range(0, 1)));
        step(1'b0, 1'b1, 20'h55555, 1'b0);
        repeat (2 * F) step(1'b0, 1'b0, 20'h0, 1'b0);
        idle_to(9, 1'b0);
        step(1'b0, 1'b1, 20'h77777, 1'b0);
        step(1'b1, 1'b1, 20'h86868, 1'b0);
        repeat (3 * F) step(1'b0, 1'b0, 20'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pops != pushes) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=%0d", pops, pushes);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
